// File: rtl/word_deserializer.sv
// Collects a stream of WORD_SIZE-bit words into LANES-wide groups under valid/ready
// handshakes on both sides; in_last closes a group early and the unused lanes read as zero.
module word_deserializer #(
  parameter int WORD_SIZE = 16,
  parameter int LANES     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WORD_SIZE-1:0]         in_data,
  input  logic                         in_valid,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic [LANES*WORD_SIZE-1:0]   out_data,
  output logic [$clog2(LANES+1)-1:0]   out_count,
  output logic                         out_last,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW = $clog2(LANES + 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        idx;
  logic [WORD_SIZE-1:0] lanes [LANES];
  logic [CW-1:0]        count;
  logic                 last;

  logic in_xfer, out_xfer, fill_close, hold_close;

  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = out_valid & out_ready;
  assign fill_close = (idx == IW'(LANES - 1)) | in_last;
  assign hold_close = (LANES == 1) | in_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL: if (in_xfer && fill_close) state_nxt = HOLD;
      HOLD: if (out_xfer) state_nxt = (in_xfer && hold_close) ? HOLD : FILL;
      default: state_nxt = FILL;
    endcase
  end

  // In HOLD the input side only moves when the consumer drains the group, so a new
  // word can slip into lane 0 in the same cycle and groups stream without bubbles.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = (state == HOLD);
    if (!reset) in_ready = (state == FILL) ? 1'b1 : out_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx   <= '0;
      count <= '0;
      last  <= 1'b0;
      for (int k = 0; k < LANES; k++) lanes[k] <= '0;
    end else if (state == FILL) begin
      if (in_xfer) begin
        lanes[idx] <= in_data;
        count      <= CW'(idx) + CW'(1);
        if (fill_close) begin
          last <= in_last;
          idx  <= '0;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end else if (out_xfer) begin
      // Clearing every lane on a restart is what makes early-closed groups zero-filled.
      for (int k = 1; k < LANES; k++) lanes[k] <= '0;
      if (in_xfer) begin
        lanes[0] <= in_data;
        count    <= CW'(1);
        if (hold_close) begin
          last <= in_last;
          idx  <= '0;
        end else begin
          last <= 1'b0;
          idx  <= IW'(1);
        end
      end else begin
        lanes[0] <= '0;
        count    <= '0;
        last     <= 1'b0;
        idx      <= '0;
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int k = 0; k < LANES; k++) out_data[k*WORD_SIZE +: WORD_SIZE] = lanes[k];
  end

  assign out_count = count;
  assign out_last  = last;

endmodule

// File: tb/tb_word_deserializer.sv
// Directed bench for word_deserializer: a 4-lane instance driven from a vector table
// plus hand-written reset sequences, and a 1-lane instance driven by a short sequence.
module tb_word_deserializer;

  logic        clk = 1'b0;
  logic        reset;

  logic [15:0] in_data;
  logic        in_valid, in_last, out_ready;
  logic        in_ready, out_valid, out_last;
  logic [63:0] out_data;
  logic [2:0]  out_count;

  logic [15:0] d1;
  logic        v1, l1, or1;
  logic        ir1, ov1, ol1;
  logic [15:0] od1;
  logic [0:0]  oc1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [15:0] d;
    logic        v, l, ordy;
    logic        e_ir, e_ov;
    logic [63:0] e_data;
    logic [2:0]  e_cnt;
    logic        e_last;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  word_deserializer #(.WORD_SIZE(16), .LANES(4)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_count(out_count), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  word_deserializer #(.WORD_SIZE(16), .LANES(1)) dut1 (
    .clk(clk), .reset(reset),
    .in_data(d1), .in_valid(v1), .in_last(l1), .in_ready(ir1),
    .out_data(od1), .out_count(oc1), .out_last(ol1),
    .out_valid(ov1), .out_ready(or1)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] d, input logic v, input logic l, input logic ordy,
                     input logic e_ir, input logic e_ov, input logic [63:0] e_data,
                     input logic [2:0] e_cnt, input logic e_last);
    vec_t r;
    r.d = d; r.v = v; r.l = l; r.ordy = ordy;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_data = e_data; r.e_cnt = e_cnt; r.e_last = e_last;
    vecs.push_back(r);
  endtask

  // One row is one clock: drive at the falling edge, check in_ready before the rising
  // edge, then check the registered outputs just after it.
  task automatic apply_stimulus(input vec_t r, input string tag);
    @(negedge clk);
    in_data = r.d; in_valid = r.v; in_last = r.l; out_ready = r.ordy;
    #1;
    check_output({tag, ".in_ready"}, 64'(in_ready), 64'(r.e_ir));
    @(posedge clk);
    #1;
    check_output({tag, ".out_valid"}, 64'(out_valid), 64'(r.e_ov));
    check_output({tag, ".out_data"},  out_data,       r.e_data);
    check_output({tag, ".out_count"}, 64'(out_count), 64'(r.e_cnt));
    check_output({tag, ".out_last"},  64'(out_last),  64'(r.e_last));
  endtask

  task automatic idle_clear(input string tag);
    vec_t r;
    r = '{d: 16'h0, v: 1'b0, l: 1'b0, ordy: 1'b1, e_ir: 1'b1, e_ov: 1'b0,
          e_data: 64'h0, e_cnt: 3'd0, e_last: 1'b0};
    apply_stimulus(r, tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vec_t r;

    reset = 1'b1;
    in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    d1 = '0; v1 = 1'b0; l1 = 1'b0; or1 = 1'b0;

    // full group 1..4
    add(16'h0001,1,0,1, 1,0, 64'h0000_0000_0000_0001, 3'd1, 0);
    add(16'h0002,1,0,1, 1,0, 64'h0000_0000_0002_0001, 3'd2, 0);
    add(16'h0003,1,0,1, 1,0, 64'h0000_0003_0002_0001, 3'd3, 0);
    add(16'h0004,1,0,1, 1,1, 64'h0004_0003_0002_0001, 3'd4, 0);
    add(16'h0000,0,0,1, 1,0, 64'h0,                   3'd0, 0);
    // early close after two words
    add(16'h00AA,1,0,1, 1,0, 64'h0000_0000_0000_00AA, 3'd1, 0);
    add(16'h00BB,1,1,1, 1,1, 64'h0000_0000_00BB_00AA, 3'd2, 1);
    add(16'h0000,0,0,1, 1,0, 64'h0,                   3'd0, 0);
    // single-word group
    add(16'h1234,1,1,1, 1,1, 64'h0000_0000_0000_1234, 3'd1, 1);
    add(16'h0000,0,0,1, 1,0, 64'h0,                   3'd0, 0);
    // in_last without in_valid is ignored
    add(16'h0000,0,1,1, 1,0, 64'h0,                   3'd0, 0);
    // back-to-back 1..12
    add(16'h0001,1,0,1, 1,0, 64'h0000_0000_0000_0001, 3'd1, 0);
    add(16'h0002,1,0,1, 1,0, 64'h0000_0000_0002_0001, 3'd2, 0);
    add(16'h0003,1,0,1, 1,0, 64'h0000_0003_0002_0001, 3'd3, 0);
    add(16'h0004,1,0,1, 1,1, 64'h0004_0003_0002_0001, 3'd4, 0);
    add(16'h0005,1,0,1, 1,0, 64'h0000_0000_0000_0005, 3'd1, 0);
    add(16'h0006,1,0,1, 1,0, 64'h0000_0000_0006_0005, 3'd2, 0);
    add(16'h0007,1,0,1, 1,0, 64'h0000_0007_0006_0005, 3'd3, 0);
    add(16'h0008,1,0,1, 1,1, 64'h0008_0007_0006_0005, 3'd4, 0);
    add(16'h0009,1,0,1, 1,0, 64'h0000_0000_0000_0009, 3'd1, 0);
    add(16'h000A,1,0,1, 1,0, 64'h0000_0000_000A_0009, 3'd2, 0);
    add(16'h000B,1,0,1, 1,0, 64'h0000_000B_000A_0009, 3'd3, 0);
    add(16'h000C,1,0,1, 1,1, 64'h000C_000B_000A_0009, 3'd4, 0);
    add(16'h0000,0,0,1, 1,0, 64'h0,                   3'd0, 0);
    // backpressure: 5 stalled cycles with the next word waiting
    add(16'h0021,1,0,0, 1,0, 64'h0000_0000_0000_0021, 3'd1, 0);
    add(16'h0022,1,0,0, 1,0, 64'h0000_0000_0022_0021, 3'd2, 0);
    add(16'h0023,1,0,0, 1,0, 64'h0000_0023_0022_0021, 3'd3, 0);
    add(16'h0024,1,0,0, 1,1, 64'h0024_0023_0022_0021, 3'd4, 0);
    for (int i = 0; i < 5; i++)
      add(16'h0031,1,0,0, 0,1, 64'h0024_0023_0022_0021, 3'd4, 0);
    add(16'h0031,1,0,1, 1,0, 64'h0000_0000_0000_0031, 3'd1, 0);
    add(16'h0032,1,0,1, 1,0, 64'h0000_0000_0032_0031, 3'd2, 0);
    add(16'h0033,1,0,1, 1,0, 64'h0000_0033_0032_0031, 3'd3, 0);
    add(16'h0034,1,0,1, 1,1, 64'h0034_0033_0032_0031, 3'd4, 0);
    add(16'h0000,0,0,1, 1,0, 64'h0,                   3'd0, 0);
    // drain and single-word last in the same cycle stays in HOLD
    add(16'h0041,1,0,1, 1,0, 64'h0000_0000_0000_0041, 3'd1, 0);
    add(16'h0042,1,0,1, 1,0, 64'h0000_0000_0042_0041, 3'd2, 0);
    add(16'h0043,1,0,1, 1,0, 64'h0000_0043_0042_0041, 3'd3, 0);
    add(16'h0044,1,0,1, 1,1, 64'h0044_0043_0042_0041, 3'd4, 0);
    add(16'h0055,1,1,1, 1,1, 64'h0000_0000_0000_0055, 3'd1, 1);
    add(16'h0000,0,0,1, 1,0, 64'h0,                   3'd0, 0);
    // in_last on the word that fills the last lane
    add(16'h0061,1,0,1, 1,0, 64'h0000_0000_0000_0061, 3'd1, 0);
    add(16'h0062,1,0,1, 1,0, 64'h0000_0000_0062_0061, 3'd2, 0);
    add(16'h0063,1,0,1, 1,0, 64'h0000_0063_0062_0061, 3'd3, 0);
    add(16'h0064,1,1,1, 1,1, 64'h0064_0063_0062_0061, 3'd4, 1);
    add(16'h0000,0,0,1, 1,0, 64'h0,                   3'd0, 0);

    repeat (2) @(posedge clk);
    #1;
    check_output("reset.in_ready",  64'(in_ready),  64'h0);
    check_output("reset.out_valid", 64'(out_valid), 64'h0);
    check_output("reset.out_data",  out_data,       64'h0);
    check_output("reset.out_count", 64'(out_count), 64'h0);
    check_output("reset.out_last",  64'(out_last),  64'h0);
    check_output("reset.l1_ready",  64'(ir1),       64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("release.in_ready", 64'(in_ready), 64'h1);

    for (int i = 0; i < vecs.size(); i++)
      apply_stimulus(vecs[i], $sformatf("row%0d", i));

    // reset in the middle of a group discards the partial lanes
    @(negedge clk);
    in_data = 16'h0070; in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    in_data = 16'h0071;
    @(negedge clk);
    in_valid = 1'b0;
    check_output("midgrp.partial", out_data, 64'h0000_0000_0071_0070);
    #2 reset = 1'b1;
    #1;
    check_output("midgrp.rst_data",  out_data,       64'h0);
    check_output("midgrp.rst_count", 64'(out_count), 64'h0);
    check_output("midgrp.rst_ready", 64'(in_ready),  64'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r.d = 16'h0010 + 16'(i); r.v = 1'b1; r.l = 1'b0; r.ordy = 1'b1; r.e_ir = 1'b1;
      r.e_ov = (i == 3); r.e_cnt = 3'(i + 1); r.e_last = 1'b0;
      r.e_data = (i == 0) ? 64'h0000_0000_0000_0010 :
                 (i == 1) ? 64'h0000_0000_0011_0010 :
                 (i == 2) ? 64'h0000_0012_0011_0010 : 64'h0013_0012_0011_0010;
      apply_stimulus(r, $sformatf("after_rst%0d", i));
    end

    // reset while a group is presented drops out_valid at once
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #3 reset = 1'b1;
    #1;
    check_output("hold_rst.out_valid", 64'(out_valid), 64'h0);
    check_output("hold_rst.out_data",  out_data,       64'h0);
    @(negedge clk);
    reset = 1'b0;
    idle_clear("hold_rst.idle");

    // single-lane instance: every accepted word is its own group
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d1 = 16'h00A0 + 16'(i); v1 = 1'b1; l1 = (i == 3); or1 = 1'b1;
      #1;
      check_output($sformatf("l1.w%0d.ready", i), 64'(ir1), 64'h1);
      @(posedge clk);
      #1;
      check_output($sformatf("l1.w%0d.valid", i), 64'(ov1), 64'h1);
      check_output($sformatf("l1.w%0d.data", i),  64'(od1), 64'h00A0 + 64'(i));
      check_output($sformatf("l1.w%0d.count", i), 64'(oc1), 64'h1);
      check_output($sformatf("l1.w%0d.last", i),  64'(ol1), (i == 3) ? 64'h1 : 64'h0);
    end
    @(negedge clk);
    d1 = 16'h00B0; v1 = 1'b1; l1 = 1'b0; or1 = 1'b0;
    #1;
    check_output("l1.stall.ready", 64'(ir1), 64'h0);
    @(posedge clk);
    #1;
    check_output("l1.stall.data", 64'(od1), 64'h00A3);
    @(negedge clk);
    or1 = 1'b1;
    #1;
    check_output("l1.resume.ready", 64'(ir1), 64'h1);
    @(posedge clk);
    #1;
    check_output("l1.resume.data", 64'(od1), 64'h00B0);
    check_output("l1.resume.last", 64'(ol1), 64'h0);
    @(negedge clk);
    v1 = 1'b0;
    @(posedge clk);
    #1;
    check_output("l1.drain.valid", 64'(ov1), 64'h0);
    check_output("l1.drain.count", 64'(oc1), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/word_deserializer.md
# word_deserializer

Sequential counterpart of the lane demultiplexer. It accepts a single stream of WORD_SIZE-bit words under a valid/ready handshake and assembles consecutive words into a LANES-wide parallel group, presented under a second valid/ready handshake. It sits between the single-word pixel/weight stream and the parallel multiply-accumulate lanes of the digit classifier. A group can be closed early with in_last; unused lanes are then zero-filled.

## Interface
- WORD_SIZE, 16, width of one stream word and of one output lane
- LANES, 4, words per output group; legal values 1 to 16
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high
- in_data  input  WORD_SIZE  stream word
- in_valid  input  1  in_data is valid this cycle
- in_last  input  1  qualified by in_valid; the word ends the current group
- in_ready  output  1  block accepts in_data this cycle
- out_data  output  LANES*WORD_SIZE  lane k is at out_data[k*WORD_SIZE +: WORD_SIZE]; lane 0 holds the first word of the group
- out_count  output  $clog2(LANES+1)  number of filled lanes, 1 to LANES, while out_valid is high
- out_last  output  1  the group was closed by in_last
- out_valid  output  1  a group is presented
- out_ready  input  1  consumer takes the group this cycle

## Operation
- State machine has two states.
  - FILL: the group is incomplete.
  - HOLD: the group is complete and presented.
- Registers:
  - idx, the next lane to write, 0 to LANES-1.
  - lane registers, LANES × WORD_SIZE.
  - a count register.
  - a last flag.
- Transfers:
  - An input transfer occurs when in_valid and in_ready are both high.
  - An output transfer occurs when out_valid and out_ready are both high.
- in_ready is 1 in FILL. In HOLD it equals out_ready, which gives pass-through at full throughput.
- out_valid is 1 exactly when the state is HOLD. out_data, out_count and out_last are registered values.
- Input transfer in FILL:
  - Write lane[idx] = in_data and set count = idx+1.
  - If idx==LANES-1 or in_last is high: go to HOLD, set last = in_last, set idx = 0.
  - Otherwise: idx = idx+1 and stay in FILL.
- HOLD with out_ready low: all registers hold, and in_ready is 0.
- HOLD with an output transfer and no input transfer: go to FILL, clear all lanes to 0, set count = 0, last = 0, idx = 0.
- HOLD with an output transfer and an input transfer in the same cycle:
  - Start the new group: lane0 = in_data, lanes 1 to LANES-1 cleared to 0, count = 1.
  - If LANES==1 or in_last is high: stay in HOLD with last = in_last, idx = 0.
  - Otherwise: go to FILL with idx = 1, last = 0.
- Zero-fill: when a group is closed early, lanes at index count and above read as 0.
- Protocol rules:
  - Upstream must hold in_data and in_last stable while in_valid is high and in_ready is low.
  - out_data, out_count and out_last are stable while out_valid is high and out_ready is low.
- in_last with in_valid low is ignored.
- If in_last arrives on a word that already fills lane LANES-1, out_last = 1 and out_count = LANES.

## Timing
- Reset values, applied asynchronously while reset is high:
  - state FILL, idx 0, all lanes 0, count 0, last 0.
  - Outputs therefore read: out_valid 0, out_count 0, out_last 0, out_data 0.
  - in_ready is forced to 0 while reset is high and is 1 from the first cycle after release.
- Latency: out_valid rises on the clock edge that accepts the closing word, i.e. it is visible in the next cycle.
- Sustained throughput is 1 word per cycle when out_ready stays high. There are no bubbles between groups.
- in_ready has a combinational path from out_ready. There is no combinational path from in_valid to any output.
- Reset asserted mid-group or during HOLD discards the partial or presented group immediately. No output transfer is reported.

## Test plan
- Full groups: reset, then send 0x0001 to 0x0004 with out_ready=1. Required:
  - out_valid for exactly one cycle.
  - out_data = {0x0004,0x0003,0x0002,0x0001}.
  - out_count = 4, out_last = 0.
- Early close: send 0x00AA and then 0x00BB with in_last. Required:
  - out_data = {0x0000,0x0000,0x00BB,0x00AA}.
  - out_count = 2, out_last = 1.
- Backpressure: hold out_ready=0 for 5 cycles after a full group. Required:
  - out_data stable and in_ready = 0 for those cycles.
  - Raising out_ready with in_valid high accepts the next word into lane 0 in that same cycle.
- Back-to-back: 12 consecutive words 1 to 12 with continuous in_valid and out_ready. Required:
  - 3 groups {4,3,2,1}, {8,7,6,5}, {12,11,10,9}.
  - in_ready never drops.
- Single-word last: in_last on the first word 0x1234. Required: out_count = 1, lanes 1 to 3 = 0, out_last = 1.
- Reset mid-group: 2 words, then reset pulse, then 4 words 0x10 to 0x13. Required:
  - No stale lanes.
  - The group output is {0x13,0x12,0x11,0x10}.
- Also run all scenarios with LANES = 1: every accepted word is presented with out_count = 1.
